// File: rtl/wdt_heartbeat_sequencer.sv
// wdt_heartbeat_sequencer
//
// Bus-master front end for the TinyQV watchdog. On an arm pulse it programs
// the countdown reload, starts the watchdog and reads back its status. It
// then collects heartbeat pulses from N_TASKS sources and writes TAP_MAGIC to
// the tap register once every task in the active mask has checked in since
// the previous tap. A watchdog interrupt while running is latched as a fault
// together with the tasks that failed to check in.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   arm                 pulse: latch cfg_* and (re)start the watchdog
//   cfg_countdown       watchdog reload value (sampled on arm)
//   cfg_task_mask       tasks required per tap round (sampled on arm)
//   checkin             per-task single-cycle heartbeat pulses
//   wdt_address         watchdog register address
//   wdt_data_in         watchdog write data
//   wdt_data_write_n    2'b11 idle, 2'b10 32-bit write
//   wdt_data_read_n     2'b11 idle, 2'b10 32-bit read
//   wdt_data_out        watchdog read data
//   wdt_data_ready      watchdog read data valid (same cycle as the read)
//   wdt_irq             watchdog timeout interrupt
//   armed               high while running and waiting for check-ins
//   tap_pulse           high for the cycle a tap write is on the bus
//   fault               high while in the fault state
//   fault_code          01 timeout, 10 verify fail, 11 bad config
//   missed_tasks        mask bits not seen when the timeout fired
//
// Optional feature (macro WDT_SEQ_WINDOW_EN): taps are spaced at least
// MIN_GAP cycles apart; a completed round waits in RUN until the gap expires.
// With the macro undefined a tap is issued the cycle after round completion.

module wdt_heartbeat_sequencer #(
  parameter int          N_TASKS   = 4,
  parameter logic [31:0] TAP_MAGIC = 32'h0000ABCD,
  parameter int          MIN_GAP   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [31:0]        cfg_countdown,
  input  logic [N_TASKS-1:0] cfg_task_mask,
  input  logic [N_TASKS-1:0] checkin,
  output logic [5:0]         wdt_address,
  output logic [31:0]        wdt_data_in,
  output logic [1:0]         wdt_data_write_n,
  output logic [1:0]         wdt_data_read_n,
  input  logic [31:0]        wdt_data_out,
  input  logic               wdt_data_ready,
  input  logic               wdt_irq,
  output logic               armed,
  output logic               tap_pulse,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [N_TASKS-1:0] missed_tasks
);

  localparam logic [5:0] ADDR_START     = 6'd1;
  localparam logic [5:0] ADDR_COUNTDOWN = 6'd2;
  localparam logic [5:0] ADDR_TAP       = 6'd3;
  localparam logic [5:0] ADDR_STATUS    = 6'd4;

  localparam logic [1:0] BUS_IDLE   = 2'b11;
  localparam logic [1:0] BUS_ACCESS = 2'b10;

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_VERIFY  = 2'b10;
  localparam logic [1:0] CODE_CONFIG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_START,
    S_VERIFY,
    S_RUN,
    S_TAP,
    S_FAULT
  } state_t;

  state_t             state_q;
  logic [N_TASKS-1:0] mask_q;
  logic [N_TASKS-1:0] seen_q;
  logic [5:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         write_n_q;
  logic [1:0]         read_n_q;
  logic               armed_q;
  logic               tap_q;
  logic               fault_q;
  logic [1:0]         code_q;
  logic [N_TASKS-1:0] missed_q;

  // seen_q only ever holds mask bits, so the round is complete exactly when
  // the accumulated set equals the mask.
  logic [N_TASKS-1:0] seen_d;
  logic               round_done_d;
  logic               verify_ok_d;
  logic               cfg_bad_d;
  logic               gap_open_d;
  logic               enter_tap_d;
  logic               enter_run_d;

  assign seen_d       = seen_q | (checkin & mask_q);
  assign round_done_d = (seen_d == mask_q);
  assign verify_ok_d  = (wdt_data_out[1:0] == 2'b11) && !wdt_data_out[2];
  assign cfg_bad_d    = (cfg_countdown == 32'd0) || (cfg_task_mask == '0);

  assign enter_tap_d = !arm && (state_q == S_RUN) && !wdt_irq
                       && round_done_d && gap_open_d;
  assign enter_run_d = !arm && (state_q == S_VERIFY) && wdt_data_ready
                       && verify_ok_d;

  // Only the enable and error bits of the status word matter.
  logic unused_rdata;
  assign unused_rdata = ^wdt_data_out[31:3];

`ifdef WDT_SEQ_WINDOW_EN
  // The counter is loaded on the edge that enters TAP (or RUN), so loading
  // MIN_GAP-1 puts the next tap write exactly MIN_GAP cycles after this one.
  localparam int              GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [GAP_W-1:0] gap_q;

  assign gap_open_d = (gap_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else if (enter_tap_d || enter_run_d) begin
      gap_q <= GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end
`else
  logic unused_gap;
  assign unused_gap = (MIN_GAP > 0);
  assign gap_open_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      seen_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_n_q <= BUS_IDLE;
      read_n_q  <= BUS_IDLE;
      armed_q   <= 1'b0;
      tap_q     <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'b00;
      missed_q  <= '0;
    end else begin
      // Bus is idle unless the state entered on this edge owns a transaction.
      addr_q    <= '0;
      wdata_q   <= '0;
      write_n_q <= BUS_IDLE;
      read_n_q  <= BUS_IDLE;
      tap_q     <= 1'b0;

      if (arm) begin
        mask_q  <= cfg_task_mask;
        armed_q <= 1'b0;
        if (cfg_bad_d) begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
          code_q  <= CODE_CONFIG;
        end else begin
          // The countdown is captured straight into the CFG write data.
          state_q   <= S_CFG;
          seen_q    <= '0;
          fault_q   <= 1'b0;
          code_q    <= 2'b00;
          missed_q  <= '0;
          addr_q    <= ADDR_COUNTDOWN;
          wdata_q   <= cfg_countdown;
          write_n_q <= BUS_ACCESS;
        end
      end else begin
        case (state_q)
          S_CFG: begin
            state_q   <= S_START;
            addr_q    <= ADDR_START;
            write_n_q <= BUS_ACCESS;
          end

          S_START: begin
            state_q  <= S_VERIFY;
            addr_q   <= ADDR_STATUS;
            read_n_q <= BUS_ACCESS;
          end

          S_VERIFY: begin
            if (wdt_data_ready) begin
              if (enter_run_d) begin
                state_q <= S_RUN;
                armed_q <= 1'b1;
              end else begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
                code_q  <= CODE_VERIFY;
              end
            end else begin
              addr_q   <= ADDR_STATUS;
              read_n_q <= BUS_ACCESS;
            end
          end

          S_RUN, S_TAP: begin
            if (wdt_irq) begin
              state_q  <= S_FAULT;
              armed_q  <= 1'b0;
              fault_q  <= 1'b1;
              code_q   <= CODE_TIMEOUT;
              missed_q <= mask_q & ~seen_q;
            end else if (state_q == S_TAP) begin
              // A check-in during the tap cycle opens the next round.
              state_q <= S_RUN;
              armed_q <= 1'b1;
              seen_q  <= checkin & mask_q;
            end else begin
              seen_q <= seen_d;
              if (enter_tap_d) begin
                state_q   <= S_TAP;
                armed_q   <= 1'b0;
                addr_q    <= ADDR_TAP;
                wdata_q   <= TAP_MAGIC;
                write_n_q <= BUS_ACCESS;
                tap_q     <= 1'b1;
              end
            end
          end

          S_IDLE, S_FAULT: begin
            state_q <= state_q;
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign wdt_address      = addr_q;
  assign wdt_data_in      = wdata_q;
  assign wdt_data_write_n = write_n_q;
  assign wdt_data_read_n  = read_n_q;
  assign armed            = armed_q;
  assign tap_pulse        = tap_q;
  assign fault            = fault_q;
  assign fault_code       = code_q;
  assign missed_tasks     = missed_q;

endmodule

// File: tb/tb_wdt_heartbeat_sequencer.sv
module tb_wdt_heartbeat_sequencer;

  localparam int          N       = 4;
  localparam int          MIN_GAP = 16;
  localparam logic [31:0] MAGIC   = 32'h0000ABCD;
`ifdef WDT_SEQ_WINDOW_EN
  localparam int SETTLE = MIN_GAP + 2;
`else
  localparam int SETTLE = 0;
`endif

  logic          clk;
  logic          rst;
  logic          arm;
  logic [31:0]   cfg_countdown;
  logic [N-1:0]  cfg_task_mask;
  logic [N-1:0]  checkin;
  logic [5:0]    wdt_address;
  logic [31:0]   wdt_data_in;
  logic [1:0]    wdt_data_write_n;
  logic [1:0]    wdt_data_read_n;
  logic [31:0]   wdt_data_out;
  logic          wdt_data_ready;
  logic          wdt_irq;
  logic          armed;
  logic          tap_pulse;
  logic          fault;
  logic [1:0]    fault_code;
  logic [N-1:0]  missed_tasks;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] verify_val = 32'h3;
  int          t, u, w, tt;

  typedef struct {
    bit          is_rd;
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;   // -1: any cycle
  } txn_t;

  txn_t exp_q[$];

  wdt_heartbeat_sequencer #(
    .N_TASKS  (N),
    .TAP_MAGIC(MAGIC),
    .MIN_GAP  (MIN_GAP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .cfg_countdown   (cfg_countdown),
    .cfg_task_mask   (cfg_task_mask),
    .checkin         (checkin),
    .wdt_address     (wdt_address),
    .wdt_data_in     (wdt_data_in),
    .wdt_data_write_n(wdt_data_write_n),
    .wdt_data_read_n (wdt_data_read_n),
    .wdt_data_out    (wdt_data_out),
    .wdt_data_ready  (wdt_data_ready),
    .wdt_irq         (wdt_irq),
    .armed           (armed),
    .tap_pulse       (tap_pulse),
    .fault           (fault),
    .fault_code      (fault_code),
    .missed_tasks    (missed_tasks)
  );

  // Watchdog model: status read answered in the same cycle.
  assign wdt_data_ready = (wdt_data_read_n == 2'b10);
  assign wdt_data_out   = wdt_data_ready ? verify_val : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit rd, input logic [5:0] a, input logic [31:0] d, input int c);
    txn_t e;
    e.is_rd = rd;
    e.addr  = a;
    e.data  = d;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SETTLE) tick();
  endtask

  // Monitor: every non-reset cycle is either an expected bus transaction or idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wdt_data_write_n == 2'b10 || wdt_data_read_n == 2'b10) begin
        $display("txn cyc=%0d %s addr=%0d data=%h tap=%0d", cyc,
                 (wdt_data_read_n == 2'b10) ? "rd" : "wr", wdt_address, wdt_data_in, tap_pulse);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_txn: got addr %0d data %h at cycle %0d, required no transaction",
                   wdt_address, wdt_data_in, cyc);
        end else begin
          txn_t e;
          bit ok;
          e  = exp_q.pop_front();
          ok = (wdt_address == e.addr) && (wdt_data_in == e.data)
               && ((wdt_data_read_n == 2'b10) == e.is_rd)
               && ((wdt_data_write_n == 2'b10) == !e.is_rd)
               && (tap_pulse == (!e.is_rd && e.addr == 6'd3))
               && (e.cyc < 0 || e.cyc == cyc);
          if (!ok) begin
            n_errors++;
            $display("FAIL bus_txn: got rd=%0d addr=%0d data=%h tap=%0d cyc=%0d, required rd=%0d addr=%0d data=%h cyc=%0d",
                     (wdt_data_read_n == 2'b10), wdt_address, wdt_data_in, tap_pulse, cyc,
                     e.is_rd, e.addr, e.data, e.cyc);
          end
        end
      end else begin
        n_checks++;
        if (wdt_address != 6'd0 || wdt_data_in != 32'd0 || tap_pulse != 1'b0
            || wdt_data_write_n != 2'b11 || wdt_data_read_n != 2'b11) begin
          n_errors++;
          $display("FAIL idle_bus: got addr=%0d data=%h wn=%b rn=%b tap=%0d at cycle %0d, required idle",
                   wdt_address, wdt_data_in, wdt_data_write_n, wdt_data_read_n, tap_pulse, cyc);
        end
      end
    end
  end

  // Arm with a good configuration and expect the full bring-up sequence.
  task automatic arm_ok(input logic [31:0] cd, input logic [N-1:0] m,
                        input logic [N-1:0] ci, input bit irq_mid);
    int k;
    k = cyc;
    push(1'b0, 6'd2, cd, k + 1);
    push(1'b0, 6'd1, 32'd0, k + 2);
    push(1'b1, 6'd4, 32'd0, k + 3);
    arm = 1'b1;
    cfg_countdown = cd;
    cfg_task_mask = m;
    checkin = ci;
    tick();
    arm = 1'b0;
    checkin = '0;
    wdt_irq = irq_mid;
    chk("arm_clears_fault", fault, 0);
    chk("arm_clears_missed", missed_tasks, 0);
    tick();
    tick();
    chk("armed_low_in_verify", armed, 0);
    tick();
    wdt_irq = 1'b0;
    chk("armed_after_verify", armed, 1);
    chk("no_fault_after_verify", fault, 0);
    settle();
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    cfg_countdown = '0;
    cfg_task_mask = '0;
    checkin = '0;
    wdt_irq = 1'b0;
    tick();
    tick();
    chk("rst_write_n", wdt_data_write_n, 2'b11);
    chk("rst_read_n", wdt_data_read_n, 2'b11);
    chk("rst_address", wdt_address, 0);
    chk("rst_data_in", wdt_data_in, 0);
    chk("rst_armed", armed, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_missed", missed_tasks, 0);
    chk("rst_tap_pulse", tap_pulse, 0);
    rst = 1'b0;
    tick();

    // Bring-up: countdown 100, tasks 0 and 1.
    arm_ok(32'd100, 4'b0011, 4'b0000, 1'b0);

    // Round from two staggered check-ins; tap the cycle after the last one.
    t = cyc;
    checkin = 4'b0001;
    tick();
    checkin = '0;
    repeat (4) tick();
    checkin = 4'b0010;
    push(1'b0, 6'd3, MAGIC, t + 6);
    tick();
    checkin = '0;
    chk("tap_pulse_high", tap_pulse, 1);
    tick();
    chk("tap_pulse_one_cycle", tap_pulse, 0);
    checkin = 4'b0100;   // outside the mask: must never tap
    repeat (6) tick();
    checkin = '0;
    settle();

    // Check-in during the tap cycle counts toward the next round.
    u = cyc;
    checkin = 4'b0011;
    push(1'b0, 6'd3, MAGIC, u + 1);
    push(1'b0, 6'd3, MAGIC, -1);
    tick();
    tick();
    checkin = '0;
    repeat (4) tick();
    settle();

    // Timeout with nobody checked in.
    repeat (2) tick();
    wdt_irq = 1'b1;
    tick();
    wdt_irq = 1'b0;
    chk("timeout_fault", fault, 1);
    chk("timeout_code", fault_code, 2'b01);
    chk("timeout_missed", missed_tasks, 4'b0011);
    chk("timeout_armed", armed, 0);
    checkin = 4'b0011;
    repeat (3) tick();
    checkin = '0;
    chk("fault_holds", fault, 1);

    // Re-arm from FAULT; irq during CFG/VERIFY is ignored.
    arm_ok(32'd50, 4'b0011, 4'b0000, 1'b1);

    // arm wins over a round-completing check-in in the same cycle.
    arm_ok(32'd77, 4'b0011, 4'b0011, 1'b0);
    repeat (4) tick();

    // Zero countdown: config fault, no bus traffic.
    arm = 1'b1;
    cfg_countdown = 32'd0;
    cfg_task_mask = 4'b0011;
    tick();
    arm = 1'b0;
    chk("zero_cd_fault", fault, 1);
    chk("zero_cd_code", fault_code, 2'b11);
    chk("zero_cd_armed", armed, 0);
    repeat (3) tick();

    // Status read 0x7 (error bit set): verify failure.
    verify_val = 32'h7;
    tt = cyc;
    push(1'b0, 6'd2, 32'd200, tt + 1);
    push(1'b0, 6'd1, 32'd0, tt + 2);
    push(1'b1, 6'd4, 32'd0, tt + 3);
    arm = 1'b1;
    cfg_countdown = 32'd200;
    cfg_task_mask = 4'b0011;
    tick();
    arm = 1'b0;
    chk("verify_pending_fault_clear", fault, 0);
    repeat (3) tick();
    chk("verify_fail_fault", fault, 1);
    chk("verify_fail_code", fault_code, 2'b10);
    chk("verify_fail_armed", armed, 0);
    verify_val = 32'h3;
    tick();

    // Zero mask: config fault.
    arm = 1'b1;
    cfg_countdown = 32'd10;
    cfg_task_mask = 4'b0000;
    tick();
    arm = 1'b0;
    chk("zero_mask_code", fault_code, 2'b11);
    chk("zero_mask_fault", fault, 1);
    repeat (2) tick();

    // Reset in the middle of the CFG write: bus idles without waiting for an edge.
    arm = 1'b1;
    cfg_countdown = 32'd100;
    cfg_task_mask = 4'b0011;
    tick();
    arm = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_write_n", wdt_data_write_n, 2'b11);
    chk("midrst_address", wdt_address, 0);
    chk("midrst_data_in", wdt_data_in, 0);
    chk("midrst_fault_code", fault_code, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Recovery after reset.
    arm_ok(32'd100, 4'b0011, 4'b0000, 1'b0);
    w = cyc;
    checkin = 4'b0011;
    push(1'b0, 6'd3, MAGIC, w + 1);
    tick();
    checkin = '0;
    tick();
    settle();

`ifdef WDT_SEQ_WINDOW_EN
    // Round completes 3 cycles after a tap; next tap lands MIN_GAP after it.
    w = cyc;
    checkin = 4'b0011;
    push(1'b0, 6'd3, MAGIC, w + 1);
    tick();
    checkin = '0;
    t = cyc;   // first tap cycle
    repeat (3) tick();
    checkin = 4'b0011;
    push(1'b0, 6'd3, MAGIC, t + MIN_GAP);
    tick();
    checkin = '0;
    repeat (MIN_GAP - 4) tick();
    chk("gap_tap_pulse", tap_pulse, 1);
    repeat (3) tick();
    checkin = 4'b0011;
    tick();
    checkin = '0;
    repeat (4) tick();
    chk("gap_wait_armed", armed, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("gap_rst_armed", armed, 0);
    chk("gap_rst_tap", tap_pulse, 0);
    chk("gap_rst_write_n", wdt_data_write_n, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
`endif

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
